// File: rtl/cpu_pkg.sv
// Shared constants for the microcoded CPU control sequencer: opcodes,
// control-word bit positions, single-bit control masks and microstep encoding.
package cpu_pkg;

  localparam int CW_W = 16;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Control-word bit positions, MSB first
  localparam int CW_HLT = 15;
  localparam int CW_MI  = 14;
  localparam int CW_RI  = 13;
  localparam int CW_RO  = 12;
  localparam int CW_IO  = 11;
  localparam int CW_II  = 10;
  localparam int CW_AI  = 9;
  localparam int CW_AO  = 8;
  localparam int CW_EO  = 7;
  localparam int CW_SU  = 6;
  localparam int CW_BI  = 5;
  localparam int CW_OI  = 4;
  localparam int CW_CE  = 3;
  localparam int CW_CO  = 2;
  localparam int CW_J   = 1;
  localparam int CW_FI  = 0;

  localparam ctrl_word_t B_HLT = ctrl_word_t'(1) << CW_HLT;
  localparam ctrl_word_t B_MI  = ctrl_word_t'(1) << CW_MI;
  localparam ctrl_word_t B_RI  = ctrl_word_t'(1) << CW_RI;
  localparam ctrl_word_t B_RO  = ctrl_word_t'(1) << CW_RO;
  localparam ctrl_word_t B_IO  = ctrl_word_t'(1) << CW_IO;
  localparam ctrl_word_t B_II  = ctrl_word_t'(1) << CW_II;
  localparam ctrl_word_t B_AI  = ctrl_word_t'(1) << CW_AI;
  localparam ctrl_word_t B_AO  = ctrl_word_t'(1) << CW_AO;
  localparam ctrl_word_t B_EO  = ctrl_word_t'(1) << CW_EO;
  localparam ctrl_word_t B_SU  = ctrl_word_t'(1) << CW_SU;
  localparam ctrl_word_t B_BI  = ctrl_word_t'(1) << CW_BI;
  localparam ctrl_word_t B_OI  = ctrl_word_t'(1) << CW_OI;
  localparam ctrl_word_t B_CE  = ctrl_word_t'(1) << CW_CE;
  localparam ctrl_word_t B_CO  = ctrl_word_t'(1) << CW_CO;
  localparam ctrl_word_t B_J   = ctrl_word_t'(1) << CW_J;
  localparam ctrl_word_t B_FI  = ctrl_word_t'(1) << CW_FI;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  // Execute steps are the ones where the opcode path is enabled.
  function automatic logic is_exec_step(input step_e s);
    return (s == T2) || (s == T3) || (s == T4);
  endfunction

endpackage

// File: rtl/ctrl_seq_step_ctr.sv
// Microstep counter with sticky HALTED flag; asynchronous clear returns to T0.
module step_ctr
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  clr,
  input  logic  last_step,
  input  logic  halt,
  output step_e step,
  output logic  halted
);

  step_e r_step;
  logic  r_halted;

  // Halt freezes the step where it was taken; only clr leaves HALTED.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else if (r_halted) begin
      r_step   <= r_step;
      r_halted <= 1'b1;
    end else if (halt) begin
      r_halted <= 1'b1;
    end else if (last_step || (r_step == T4)) begin
      r_step <= T0;
    end else begin
      r_step <= step_e'(r_step + 3'd1);
    end
  end

  assign step   = r_step;
  assign halted = r_halted;

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: decodes microstep, opcode and flags into the control word.
// Optional conditional jumps (JC/JZ) are enabled by defining COND_JUMP_EN.
module ctrl_seq
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  opcode,
  input  logic        carry,
  input  logic        zero,
  output logic        ir_oa,
  output logic [15:0] ctrl_word,
  output logic [2:0]  step
);

  step_e      w_step;
  logic       w_halted;
  logic       w_halt;
  logic       w_last_step;
  ctrl_word_t w_exec_word;

`ifndef COND_JUMP_EN
  logic w_unused_flags;
  assign w_unused_flags = carry ^ zero;
`endif

  step_ctr u_step_ctr (
    .clk       (clk),
    .clr       (clr),
    .last_step (w_last_step),
    .halt      (w_halt),
    .step      (w_step),
    .halted    (w_halted)
  );

  // Opcode is only looked at in execute steps, so fetch never depends on it.
  always_comb begin
    w_exec_word = '0;
    w_last_step = 1'b1;
    case (w_step)
      T0: begin
        w_exec_word = B_CO | B_MI;
        w_last_step = 1'b0;
      end
      T1: begin
        w_exec_word = B_RO | B_II | B_CE;
        w_last_step = 1'b0;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_exec_word = B_IO | B_MI;
            w_last_step = 1'b0;
          end
          OP_LDI: w_exec_word = B_IO | B_AI;
          OP_JMP: w_exec_word = B_IO | B_J;
          OP_OUT: w_exec_word = B_AO | B_OI;
          OP_HLT: w_exec_word = B_HLT;
`ifdef COND_JUMP_EN
          OP_JC:  w_exec_word = carry ? (B_IO | B_J) : '0;
          OP_JZ:  w_exec_word = zero  ? (B_IO | B_J) : '0;
`endif
          default: w_exec_word = '0;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: w_exec_word = B_RO | B_AI;
          OP_ADD, OP_SUB: begin
            w_exec_word = B_RO | B_BI;
            w_last_step = 1'b0;
          end
          OP_STA: w_exec_word = B_AO | B_RI;
          default: w_exec_word = '0;
        endcase
      end
      T4: begin
        case (opcode)
          OP_ADD:  w_exec_word = B_EO | B_AI | B_FI;
          OP_SUB:  w_exec_word = B_EO | B_AI | B_FI | B_SU;
          default: w_exec_word = '0;
        endcase
      end
      default: w_exec_word = '0;
    endcase
  end

  assign w_halt = !w_halted && (w_step == T2) && (opcode == OP_HLT);

  // clr forces outputs quiet at once, independent of the counter's state.
  assign ctrl_word = clr ? 16'h0000 : (w_halted ? B_HLT : w_exec_word);
  assign ir_oa     = !clr && (w_halted || is_exec_step(w_step));
  assign step      = w_step;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: randomized instruction stream against a
// table-driven model of the microcode; honours COND_JUMP_EN if defined.
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic        carry = 1'b0;
  logic        zero = 1'b0;
  logic        ir_oa;
  logic [15:0] ctrl_word;
  logic [2:0]  step;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef COND_JUMP_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

  ctrl_seq dut (
    .clk       (clk),
    .clr       (clr),
    .opcode    (opcode),
    .carry     (carry),
    .zero      (zero),
    .ir_oa     (ir_oa),
    .ctrl_word (ctrl_word),
    .step      (step)
  );

  always #5 clk = ~clk;

  // Number of microsteps an instruction occupies.
  function automatic int exp_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input logic [3:0] op, input int k,
                                           input logic c, input logic z);
    if (k == 0) return CO | MI;
    if (k == 1) return RO | II | CE;
    case (op)
      4'h1: return (k == 2) ? (IO | MI) : (RO | AI);
      4'h2: return (k == 2) ? (IO | MI) : (k == 3) ? (RO | BI) : (EO | AI | FI);
      4'h3: return (k == 2) ? (IO | MI) : (k == 3) ? (RO | BI) : (EO | AI | FI | SU);
      4'h4: return (k == 2) ? (IO | MI) : (AO | RI);
      4'h5: return IO | AI;
      4'h6: return IO | J;
      4'h7: return (COND && c) ? (IO | J) : 16'h0000;
      4'h8: return (COND && z) ? (IO | J) : 16'h0000;
      4'hE: return AO | OI;
      4'hF: return HLT;
      default: return 16'h0000;
    endcase
  endfunction

  // Expected {ir_oa, step, ctrl_word} for microstep k of an instruction.
  function automatic logic [19:0] exp_obs(input logic [3:0] op, input int k,
                                          input logic c, input logic z);
    return {(k >= 2), 3'(k), exp_word(op, k, c, z)};
  endfunction

  // Drive inputs on the falling edge and settle before observing.
  task automatic cycle(input logic [3:0] op, input logic c, input logic z);
    @(negedge clk);
    opcode = op;
    carry  = c;
    zero   = z;
    #1;
  endtask

  task automatic test_reset;
    $display("instr reset hold and release");
    #1;
    n_checks++;
    if ({ir_oa, step, ctrl_word} !== 20'h0) begin
      n_fails++;
      $display("FAIL reset_hold got ir_oa=%b step=%0d ctrl=%h expected 0/0/0000",
               ir_oa, step, ctrl_word);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ir_oa, step, ctrl_word} !== 20'h0) begin
      n_fails++;
      $display("FAIL reset_clocked got ir_oa=%b step=%0d ctrl=%h expected 0/0/0000",
               ir_oa, step, ctrl_word);
    end
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    n_checks++;
    if ({ir_oa, step, ctrl_word} !== {1'b0, 3'd0, 16'h4004}) begin
      n_fails++;
      $display("FAIL reset_release got ir_oa=%b step=%0d ctrl=%h expected 0/0/4004",
               ir_oa, step, ctrl_word);
    end
  endtask

  task automatic test_fetch;
    logic [19:0] e;
    $display("instr fetch opcode=1");
    for (int k = 0; k < exp_len(4'h1); k++) begin
      cycle((k < 2) ? 4'($urandom_range(0, 15)) : 4'h1, 1'b0, 1'b0);
      e = exp_obs(4'h1, k, 1'b0, 1'b0);
      n_checks++;
      if ({ir_oa, step, ctrl_word} !== e) begin
        n_fails++;
        $display("FAIL fetch k=%0d got ir_oa=%b step=%0d ctrl=%h expected ir_oa=%b step=%0d ctrl=%h",
                 k, ir_oa, step, ctrl_word, e[19], e[18:16], e[15:0]);
      end
    end
  endtask

  // ADD then SUB back to back: the SUB T0 confirms the return after T4.
  task automatic test_add_timing;
    logic [19:0] e;
    logic [3:0]  ops [2];
    ops[0] = 4'h2;
    ops[1] = 4'h3;
    for (int i = 0; i < 2; i++) begin
      $display("instr add_timing opcode=%h", ops[i]);
      for (int k = 0; k < exp_len(ops[i]); k++) begin
        cycle((k < 2) ? 4'($urandom_range(0, 15)) : ops[i], 1'($urandom), 1'($urandom));
        e = exp_obs(ops[i], k, carry, zero);
        n_checks++;
        if ({ir_oa, step, ctrl_word} !== e) begin
          n_fails++;
          $display("FAIL add_timing op=%h k=%0d got ir_oa=%b step=%0d ctrl=%h expected ir_oa=%b step=%0d ctrl=%h",
                   ops[i], k, ir_oa, step, ctrl_word, e[19], e[18:16], e[15:0]);
        end
      end
    end
  endtask

  task automatic test_ldi_length;
    logic [19:0] e;
    logic [3:0]  ops [3];
    ops[0] = 4'h5;
    ops[1] = 4'h5;
    ops[2] = 4'h1;
    for (int i = 0; i < 3; i++) begin
      $display("instr ldi_length opcode=%h", ops[i]);
      for (int k = 0; k < exp_len(ops[i]); k++) begin
        cycle((k < 2) ? 4'($urandom_range(0, 15)) : ops[i], 1'b0, 1'b0);
        e = exp_obs(ops[i], k, 1'b0, 1'b0);
        n_checks++;
        if ({ir_oa, step, ctrl_word} !== e) begin
          n_fails++;
          $display("FAIL ldi_length op=%h k=%0d got ir_oa=%b step=%0d ctrl=%h expected ir_oa=%b step=%0d ctrl=%h",
                   ops[i], k, ir_oa, step, ctrl_word, e[19], e[18:16], e[15:0]);
        end
      end
    end
  endtask

  task automatic test_cond_jump;
    logic [19:0] e;
    logic [3:0]  op;
    logic        c;
    logic        z;
    for (int i = 0; i < 8; i++) begin
      op = (i[1] == 1'b0) ? 4'h7 : 4'h8;
      c  = (op == 4'h7) ? i[0] : 1'($urandom);
      z  = (op == 4'h8) ? i[0] : 1'($urandom);
      $display("instr cond_jump opcode=%h carry=%b zero=%b", op, c, z);
      for (int k = 0; k < exp_len(op); k++) begin
        cycle((k < 2) ? 4'($urandom_range(0, 15)) : op, c, z);
        e = exp_obs(op, k, c, z);
        n_checks++;
        if ({ir_oa, step, ctrl_word} !== e) begin
          n_fails++;
          $display("FAIL cond_jump op=%h c=%b z=%b k=%0d got ir_oa=%b step=%0d ctrl=%h expected ir_oa=%b step=%0d ctrl=%h",
                   op, c, z, k, ir_oa, step, ctrl_word, e[19], e[18:16], e[15:0]);
        end
      end
    end
  endtask

  task automatic test_halt;
    logic [19:0] e;
    $display("instr halt opcode=f");
    for (int k = 0; k < exp_len(4'hF); k++) begin
      cycle((k < 2) ? 4'($urandom_range(0, 15)) : 4'hF, 1'b0, 1'b0);
      e = exp_obs(4'hF, k, 1'b0, 1'b0);
      n_checks++;
      if ({ir_oa, step, ctrl_word} !== e) begin
        n_fails++;
        $display("FAIL halt_entry k=%0d got ir_oa=%b step=%0d ctrl=%h expected ir_oa=%b step=%0d ctrl=%h",
                 k, ir_oa, step, ctrl_word, e[19], e[18:16], e[15:0]);
      end
    end
    for (int n = 0; n < 10; n++) begin
      cycle(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      n_checks++;
      if ({ir_oa, step, ctrl_word} !== {1'b1, 3'd2, 16'h8000}) begin
        n_fails++;
        $display("FAIL halted cycle=%0d got ir_oa=%b step=%0d ctrl=%h expected 1/2/8000",
                 n, ir_oa, step, ctrl_word);
      end
    end
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if ({ir_oa, step, ctrl_word} !== 20'h0) begin
      n_fails++;
      $display("FAIL halt_clr got ir_oa=%b step=%0d ctrl=%h expected 0/0/0000",
               ir_oa, step, ctrl_word);
    end
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    n_checks++;
    if ({ir_oa, step, ctrl_word} !== {1'b0, 3'd0, 16'h4004}) begin
      n_fails++;
      $display("FAIL halt_release got ir_oa=%b step=%0d ctrl=%h expected 0/0/4004",
               ir_oa, step, ctrl_word);
    end
  endtask

  // clr raised between edges in the middle of STA's T3.
  task automatic test_async_reset;
    logic [19:0] e;
    $display("instr async_reset opcode=4 aborted at T3");
    for (int k = 0; k < 4; k++) begin
      cycle((k < 2) ? 4'($urandom_range(0, 15)) : 4'h4, 1'b0, 1'b0);
      e = exp_obs(4'h4, k, 1'b0, 1'b0);
      n_checks++;
      if ({ir_oa, step, ctrl_word} !== e) begin
        n_fails++;
        $display("FAIL async_pre k=%0d got ir_oa=%b step=%0d ctrl=%h expected ir_oa=%b step=%0d ctrl=%h",
                 k, ir_oa, step, ctrl_word, e[19], e[18:16], e[15:0]);
      end
    end
    #2 clr = 1'b1;
    #1;
    n_checks++;
    if ({ir_oa, step, ctrl_word} !== 20'h0) begin
      n_fails++;
      $display("FAIL async_mid_t3 got ir_oa=%b step=%0d ctrl=%h expected 0/0/0000",
               ir_oa, step, ctrl_word);
    end
    @(posedge clk);
    #2 clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [19:0] e;
    logic [3:0]  op;
    logic        c;
    logic        z;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      c  = 1'($urandom);
      z  = 1'($urandom);
      $display("instr back_to_back #%0d opcode=%h carry=%b zero=%b", i, op, c, z);
      for (int k = 0; k < exp_len(op); k++) begin
        cycle((k < 2) ? 4'($urandom_range(0, 15)) : op, c, z);
        e = exp_obs(op, k, c, z);
        n_checks++;
        if ({ir_oa, step, ctrl_word} !== e) begin
          n_fails++;
          $display("FAIL back_to_back op=%h c=%b z=%b k=%0d got ir_oa=%b step=%0d ctrl=%h expected ir_oa=%b step=%0d ctrl=%h",
                   op, c, z, k, ir_oa, step, ctrl_word, e[19], e[18:16], e[15:0]);
        end
        n_checks++;
        if ($countones(ctrl_word & (RO | IO | AO | EO | CO)) > 1) begin
          n_fails++;
          $display("FAIL bus_drivers op=%h k=%0d got ctrl=%h expected at most one driver",
                   op, k, ctrl_word);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_add_timing();
    test_ldi_length();
    test_cond_jump();
    test_async_reset();
    test_back_to_back();
    test_halt();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
